quad_decoder: RTL and testbench

//  Front-end stage for up_down_counter. Turns raw asynchronous quadrature inputs (A/B) into a

---
 rtl/quad_decoder.sv | 189 ++++++++++++++++++
 tb/tb_quad_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature front end: synchronises and glitch-filters A/B, then decodes Gray-code moves
// into a one-cycle step strobe, a held direction level and a sticky illegal-jump flag.
module quad_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_W      = 3,
   parameter int FILT_CNT    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a_in,
   input  logic       b_in,
   input  logic       en,
   input  logic       err_clr,
   output logic       step,
   output logic       up_down,
   output logic       err,
   output logic [1:0] state,
   output logic       ready
);

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } fsm_t;

   localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILT_CNT - 1);
   localparam logic [FILT_W-1:0] CNT_ONE  = FILT_W'(1);
   localparam logic [FILT_W-1:0] CNT_ZERO = FILT_W'(0);

   // Position of a code along the forward cycle 00 -> 01 -> 11 -> 10.
   function automatic logic [1:0] gray_pos(input logic [1:0] code);
      logic [1:0] pos;
      case (code)
         2'b00:   pos = 2'd0;
         2'b01:   pos = 2'd1;
         2'b11:   pos = 2'd2;
         2'b10:   pos = 2'd3;
         default: pos = 2'd0;
      endcase
      return pos;
   endfunction

   logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
   logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
   fsm_t                   fsm_q, fsm_d;
   logic [FILT_W-1:0]      init_cnt_q, init_cnt_d;
   logic [1:0]             ab_last_q, ab_last_d;
   logic [FILT_W-1:0]      a_cnt_q, a_cnt_d;
   logic [FILT_W-1:0]      b_cnt_q, b_cnt_d;
   logic [1:0]             state_q, state_d;
   logic [1:0]             prev_q, prev_d;
   logic                   step_q, step_d;
   logic                   up_down_q, up_down_d;
   logic                   err_q, err_d;
   logic                   ready_q, ready_d;

   logic                   a_s, b_s;
   logic                   err_set_s;
   logic [1:0]             pos_diff_s;

   assign a_s = a_sync_q[SYNC_STAGES-1];
   assign b_s = b_sync_q[SYNC_STAGES-1];

   // Next-state logic for synchronisers, FSM, filters and decode.
   always_comb begin
      a_sync_d   = {a_sync_q[SYNC_STAGES-2:0], a_in};
      b_sync_d   = {b_sync_q[SYNC_STAGES-2:0], b_in};
      fsm_d      = fsm_q;
      init_cnt_d = init_cnt_q;
      ab_last_d  = ab_last_q;
      a_cnt_d    = a_cnt_q;
      b_cnt_d    = b_cnt_q;
      state_d    = state_q;
      prev_d     = prev_q;
      step_d     = 1'b0;
      up_down_d  = up_down_q;
      err_set_s  = 1'b0;
      pos_diff_s = gray_pos(state_q) - gray_pos(prev_q);

      case (fsm_q)
         ST_INIT: begin
            if ({a_s, b_s} == ab_last_q) begin
               if (init_cnt_q == CNT_LAST) begin
                  state_d    = {a_s, b_s};
                  prev_d     = {a_s, b_s};
                  fsm_d      = ST_TRACK;
                  init_cnt_d = CNT_ZERO;
               end else begin
                  init_cnt_d = init_cnt_q + CNT_ONE;
               end
            end else begin
               init_cnt_d = CNT_ZERO;
               ab_last_d  = {a_s, b_s};
            end
         end
         ST_TRACK: begin
            prev_d = state_q;
            if (a_s != state_q[1]) begin
               if (a_cnt_q == CNT_LAST) begin
                  state_d[1] = a_s;
                  a_cnt_d    = CNT_ZERO;
               end else begin
                  a_cnt_d = a_cnt_q + CNT_ONE;
               end
            end else begin
               a_cnt_d = CNT_ZERO;
            end
            if (b_s != state_q[0]) begin
               if (b_cnt_q == CNT_LAST) begin
                  state_d[0] = b_s;
                  b_cnt_d    = CNT_ZERO;
               end else begin
                  b_cnt_d = b_cnt_q + CNT_ONE;
               end
            end else begin
               b_cnt_d = CNT_ZERO;
            end
         end
         default: begin
            fsm_d = ST_INIT;
         end
      endcase

      // Decode the commit made last cycle, one cycle behind the state register.
      if (en && (prev_q != state_q)) begin
         if ((prev_q ^ state_q) == 2'b11) begin
            err_set_s = 1'b1;
         end else begin
            step_d    = 1'b1;
            up_down_d = (pos_diff_s == 2'd1);
         end
      end else begin
         step_d = 1'b0;
      end

      err_d = err_q;
      if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
      if (err_set_s) begin
         err_d = 1'b1;
      end else begin
         err_d = err_d;
      end
      ready_d = (fsm_d == ST_TRACK);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_sync_q   <= {SYNC_STAGES{1'b0}};
         b_sync_q   <= {SYNC_STAGES{1'b0}};
         fsm_q      <= ST_INIT;
         init_cnt_q <= CNT_ZERO;
         ab_last_q  <= 2'b00;
         a_cnt_q    <= CNT_ZERO;
         b_cnt_q    <= CNT_ZERO;
         state_q    <= 2'b00;
         prev_q     <= 2'b00;
         step_q     <= 1'b0;
         up_down_q  <= 1'b1;
         err_q      <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         a_sync_q   <= a_sync_d;
         b_sync_q   <= b_sync_d;
         fsm_q      <= fsm_d;
         init_cnt_q <= init_cnt_d;
         ab_last_q  <= ab_last_d;
         a_cnt_q    <= a_cnt_d;
         b_cnt_q    <= b_cnt_d;
         state_q    <= state_d;
         prev_q     <= prev_d;
         step_q     <= step_d;
         up_down_q  <= up_down_d;
         err_q      <= err_d;
         ready_q    <= ready_d;
      end
   end

   assign step    = step_q;
   assign up_down = up_down_q;
   assign err     = err_q;
   assign state   = state_q;
   assign ready   = ready_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed vector table, hand-written timing sequences and a
// randomized run, all checked against a cycle-level behavioural model.
module tb_quad_decoder;

   localparam int SYNC_STAGES = 2;
   localparam int FILT_CNT    = 4;

   logic       clk = 1'b0;
   logic       rst, a_in, b_in, en, err_clr;
   logic       step, up_down, err, ready;
   logic [1:0] state;

   int n_vec = 0;
   int n_bad = 0;
   int step_cnt = 0;

   quad_decoder #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(3), .FILT_CNT(FILT_CNT)) dut (
      .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .en(en), .err_clr(err_clr),
      .step(step), .up_down(up_down), .err(err), .state(state), .ready(ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       a, b, en, clr;
      int         cyc;
      logic [1:0] st;
      int         steps;
      logic       ud, er;
   } vec_t;
   vec_t tbl[$];

   // Behavioural model: delay lines for the synchroniser, run lengths for the filters.
   bit         ma_q[$], mb_q[$];
   int         m_init_run, m_ra, m_rb;
   logic [1:0] m_last, m_state, m_prev;
   bit         m_track, m_step, m_ud, m_err, m_ready;

   function automatic int gpos(input logic [1:0] v);
      return (v == 2'b00) ? 0 : (v == 2'b01) ? 1 : (v == 2'b11) ? 2 : 3;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      ma_q = {};
      mb_q = {};
      for (int i = 0; i < SYNC_STAGES; i++) begin
         ma_q.push_back(1'b0);
         mb_q.push_back(1'b0);
      end
      m_init_run = 0; m_ra = 0; m_rb = 0;
      m_last = 2'b00; m_state = 2'b00; m_prev = 2'b00;
      m_track = 1'b0; m_step = 1'b0; m_ud = 1'b1; m_err = 1'b0; m_ready = 1'b0;
   endtask

   task automatic model_edge();
      bit         as, bs, set;
      int         d;
      logic [1:0] ab;
      as = ma_q[0];
      bs = mb_q[0];
      ma_q.delete(0); ma_q.push_back(a_in);
      mb_q.delete(0); mb_q.push_back(b_in);
      m_step = 1'b0;
      set = 1'b0;
      if (en && (m_prev != m_state)) begin
         d = (gpos(m_state) - gpos(m_prev) + 4) % 4;
         if (d == 2) set = 1'b1;
         else begin
            m_step = 1'b1;
            m_ud = (d == 1);
         end
      end
      if (set) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      ab = {as, bs};
      if (!m_track) begin
         if (ab == m_last) begin
            m_init_run++;
            if (m_init_run == FILT_CNT) begin
               m_track = 1'b1; m_ready = 1'b1; m_state = ab; m_prev = ab;
            end
         end else begin
            m_init_run = 0;
            m_last = ab;
         end
      end else begin
         m_prev = m_state;
         m_ra = (as != m_state[1]) ? m_ra + 1 : 0;
         m_rb = (bs != m_state[0]) ? m_rb + 1 : 0;
         if (m_ra == FILT_CNT) begin m_state[1] = as; m_ra = 0; end
         if (m_rb == FILT_CNT) begin m_state[0] = bs; m_rb = 0; end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      if (step === 1'b1) step_cnt++;
      chk("model", {2'b00, state, step, up_down, err, ready},
          {2'b00, m_state, m_step, m_ud, m_err, m_ready});
   endtask

   task automatic add(input logic a, b, e, c, input int cyc, input logic [1:0] st,
                      input int steps, input logic ud, er);
      vec_t v;
      v.a = a; v.b = b; v.en = e; v.clr = c; v.cyc = cyc;
      v.st = st; v.steps = steps; v.ud = ud; v.er = er;
      tbl.push_back(v);
   endtask

   initial begin
      rst = 1'b0; a_in = 1'b0; b_in = 1'b0; en = 1'b1; err_clr = 1'b0;
      model_reset();

      // Forward remainder, reverse cycle, glitch pulses, jump/clear, disabled tracking.
      add(1,1,1,0,20, 2'b11,1,1,0); add(1,0,1,0,20, 2'b10,1,1,0); add(0,0,1,0,20, 2'b00,1,1,0);
      add(1,0,1,0,20, 2'b10,1,0,0); add(1,1,1,0,20, 2'b11,1,0,0); add(0,1,1,0,20, 2'b01,1,0,0);
      add(0,0,1,0,20, 2'b00,1,0,0);
      add(1,0,1,0,3,  2'b00,0,0,0); add(0,0,1,0,17, 2'b00,0,0,0);
      add(1,0,1,0,4,  2'b00,0,0,0); add(0,0,1,0,20, 2'b00,2,1,0);
      add(1,1,1,0,20, 2'b11,0,1,1); add(1,1,1,1,1,  2'b11,0,1,0); add(1,1,1,0,5,  2'b11,0,1,0);
      add(0,1,1,0,20, 2'b01,1,0,0); add(0,0,1,0,20, 2'b00,1,0,0);
      add(0,1,0,0,20, 2'b01,0,0,0); add(1,1,0,0,20, 2'b11,0,0,0); add(1,1,1,0,20, 2'b11,0,0,0);

      // Reset hold and initial capture timing.
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      step_cnt = 0;
      for (int c = 1; c <= FILT_CNT; c++) begin
         tick();
         chk("ready_timing", {7'd0, ready}, {7'd0, (c == FILT_CNT)});
      end
      chk("init_state", {6'd0, state}, 8'd0);
      repeat (6) tick();
      chk("init_no_step", step_cnt[7:0], 8'd0);

      // Exact step latency: SYNC_STAGES + FILT_CNT + 1 cycles.
      b_in = 1'b1;
      step_cnt = 0;
      for (int c = 1; c <= 9; c++) begin
         tick();
         chk("step_latency", {7'd0, step}, {7'd0, (c == SYNC_STAGES + FILT_CNT + 1)});
      end
      chk("latency_dir", {6'd0, state, up_down}, {6'd0, 2'b01, 1'b1});

      foreach (tbl[i]) begin
         a_in = tbl[i].a; b_in = tbl[i].b; en = tbl[i].en; err_clr = tbl[i].clr;
         step_cnt = 0;
         repeat (tbl[i].cyc) tick();
         err_clr = 1'b0;
         chk($sformatf("tbl%0d_state", i), {6'd0, state}, {6'd0, tbl[i].st});
         chk($sformatf("tbl%0d_steps", i), step_cnt[7:0], tbl[i].steps[7:0]);
         chk($sformatf("tbl%0d_dir_err", i), {6'd0, up_down, err}, {6'd0, tbl[i].ud, tbl[i].er});
      end

      // Clear coincident with a new illegal jump: set wins.
      a_in = 1'b0; b_in = 1'b0;
      repeat (SYNC_STAGES + FILT_CNT) tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr_vs_set", {7'd0, err}, 8'd1);
      chk("jump_state", {6'd0, state}, 8'd0);

      // Reset in the middle of a pending transition.
      a_in = 1'b1;
      repeat (5) tick();
      rst = 1'b0;
      #1;
      model_reset();
      chk("mid_reset", {3'd0, state, step, up_down, err}, {3'd0, 2'b00, 1'b0, 1'b1, 1'b0});
      chk("mid_reset_ready", {7'd0, ready}, 8'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Randomized run against the model.
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 9) == 0) a_in = ~a_in;
         if ($urandom_range(0, 9) == 0) b_in = ~b_in;
         if ($urandom_range(0, 99) == 0) en = ~en;
         err_clr = ($urandom_range(0, 29) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
